// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// FSM that sequences a shared-memory multicycle RV32I datapath (one memory for
// instructions and data, one ALU reused for PC+4, branch target and execution).
// Outputs are Moore decodes of the state, except PCWrite (which includes the
// branch-taken term), ALUControl (decoded from ALUOp and funct fields) and ImmSrc
// (decoded from op).
//
// Optional feature macro: MC_CTRL_MEM_WAIT_EN
//   When defined, the mem_ready port exists and FETCH, MEMREAD and MEMWRITE hold
//   until mem_ready=1. When undefined, memory states always last one cycle.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset; forces state to FETCH
//   op             instruction [6:0]
//   funct3         instruction [14:12]
//   funct7b5       instruction [30]
//   Zero           ALU zero flag
//   mem_ready      memory access complete (MC_CTRL_MEM_WAIT_EN only)
//   PCWrite        PC register enable
//   AdrSrc         memory address select: 0 PC, 1 Result
//   MemWrite       data memory write enable
//   IRWrite        instruction register / OldPC enable
//   ResultSrc      00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA        00 PC, 01 OldPC, 10 A
//   ALUSrcB        00 B, 01 ImmExt, 10 constant 4
//   ImmSrc         00 I, 01 S, 10 B, 11 J
//   RegWrite       register file write enable
//   ALUControl     000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal_instr  one-cycle pulse in DECODE on an unsupported opcode

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e     state_q, state_d;
    state_e     dec_state;
    logic       mem_rdy;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Under reset the selects show FETCH values so the datapath is already
    // pointed at the PC when reset releases.
    assign dec_state = reset ? StFetch : state_q;

    always_comb begin
        state_d       = StFetch;
        pc_update     = 1'b0;
        branch        = 1'b0;
        alu_op        = 2'b00;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        RegWrite      = 1'b0;
        illegal_instr = 1'b0;

        case (dec_state)
            StFetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // IR and PC only capture once the fetch has actually returned.
                IRWrite   = mem_rdy;
                pc_update = mem_rdy;
                state_d   = mem_rdy ? StDecode : StFetch;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIType:         state_d = StExecuteI;
                    OpBranch:        state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default: begin
                        state_d       = StFetch;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc  = 1'b1;
                state_d = mem_rdy ? StMemWb : StMemRead;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_rdy ? StFetch : StMemWrite;
            end
            StExecuteR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StExecuteI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
            end
            StBeq: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            StJal: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (reset) begin
            pc_update     = 1'b0;
            branch        = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            MemWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    assign PCWrite = pc_update | (branch & Zero);

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OpStore:  ImmSrc = 2'b01;
            OpBranch: ImmSrc = 2'b10;
            OpJal:    ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [3:0] SF  = 4'd0;   // FETCH
    localparam logic [3:0] SD  = 4'd1;   // DECODE
    localparam logic [3:0] SMA = 4'd2;   // MEMADR
    localparam logic [3:0] SMR = 4'd3;   // MEMREAD
    localparam logic [3:0] SMB = 4'd4;   // MEMWB
    localparam logic [3:0] SMW = 4'd5;   // MEMWRITE
    localparam logic [3:0] SER = 4'd6;   // EXECUTER
    localparam logic [3:0] SEI = 4'd7;   // EXECUTEI
    localparam logic [3:0] SAW = 4'd8;   // ALUWB
    localparam logic [3:0] SBQ = 4'd9;   // BEQ
    localparam logic [3:0] SJ  = 4'd10;  // JAL

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
`ifdef MC_CTRL_MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;

    int tests = 0;
    int fails = 0;
    int rw_seen = 0;

    logic [16:0] sb_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk          (clk),
        .reset        (reset),
        .op           (instr[6:0]),
        .funct3       (instr[14:12]),
        .funct7b5     (instr[30]),
        .Zero         (zero),
`ifdef MC_CTRL_MEM_WAIT_EN
        .mem_ready    (mem_ready),
`endif
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ImmSrc       (ImmSrc),
        .RegWrite     (RegWrite),
        .ALUControl   (ALUControl),
        .illegal_instr(illegal_instr)
    );

    // Reference outputs, transcribed from the state table.
    // Packing: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
    //           ImmSrc, RegWrite, ALUControl, illegal_instr}
    function automatic logic [16:0] exp_out(logic [3:0] st, logic [31:0] ins, logic z,
                                            logic rst, logic mr);
        logic [6:0] o;
        logic       pcu, br, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sbv, aop, imm;
        logic [2:0] ac;
        o = ins[6:0];
        {pcu, br, adr, mw, irw, rw, ill} = '0;
        {rs, sa, sbv, aop} = '0;
        case (st)
            SF:  begin irw = mr; pcu = mr; sbv = 2'b10; rs = 2'b10; end
            SD:  begin
                sa = 2'b01; sbv = 2'b01;
                ill = !(o == 7'h03 || o == 7'h23 || o == 7'h33 || o == 7'h13 ||
                        o == 7'h63 || o == 7'h6F);
            end
            SMA: begin sa = 2'b10; sbv = 2'b01; end
            SMR: begin adr = 1'b1; end
            SMB: begin rs = 2'b01; rw = 1'b1; end
            SMW: begin adr = 1'b1; mw = 1'b1; end
            SER: begin sa = 2'b10; aop = 2'b10; end
            SEI: begin sa = 2'b10; sbv = 2'b01; aop = 2'b10; end
            SAW: begin rw = 1'b1; end
            SBQ: begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
            SJ:  begin sa = 2'b01; sbv = 2'b10; pcu = 1'b1; end
            default: ;
        endcase
        if (aop == 2'b00)      ac = 3'b000;
        else if (aop == 2'b01) ac = 3'b001;
        else begin
            case (ins[14:12])
                3'b000:  ac = (o[5] && ins[30]) ? 3'b001 : 3'b000;
                3'b010:  ac = 3'b101;
                3'b110:  ac = 3'b011;
                3'b111:  ac = 3'b010;
                default: ac = 3'b000;
            endcase
        end
        if (o == 7'h23)      imm = 2'b01;
        else if (o == 7'h63) imm = 2'b10;
        else if (o == 7'h6F) imm = 2'b11;
        else                 imm = 2'b00;
        if (rst) begin
            pcu = 1'b0; br = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0; ill = 1'b0;
        end
        return {pcu | (br & z), adr, mw, irw, rs, sa, sbv, imm, rw, ac, ill};
    endfunction

    // Drive one cycle of inputs and queue the outputs the DUT owes for it.
    task automatic run_cycle(input string tag, input logic [3:0] st, input logic [31:0] ins,
                             input logic z, input logic rst, input logic mr);
        reset = rst;
        instr = ins;
        zero  = z;
`ifdef MC_CTRL_MEM_WAIT_EN
        mem_ready = mr;
`endif
        sb_q.push_back(exp_out(st, ins, z, rst, mr));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic check_rw(input string tag, input int want);
        tests++;
        if (rw_seen != want) begin
            fails++;
            $display("FAIL %s: RegWrite cycles got %0d expected %0d", tag, rw_seen, want);
        end
        rw_seen = 0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [16:0] e, a;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            a = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                 RegWrite, ALUControl, illegal_instr};
            tests++;
            if (RegWrite) rw_seen++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: outputs got %05h expected %05h", t, a, e);
            end
        end
    end

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        z;
        int          n;
        logic [23:0] seq;   // state k in seq[4k +: 4]
        int          rw;    // expected RegWrite cycles
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"add",      32'h002081B3, 1'b0, 4, {8'h0, SAW, SER, SD, SF}, 1};
        vecs[1]  = '{"sub",      32'h402081B3, 1'b0, 4, {8'h0, SAW, SER, SD, SF}, 1};
        vecs[2]  = '{"and",      32'h0020F1B3, 1'b0, 4, {8'h0, SAW, SER, SD, SF}, 1};
        vecs[3]  = '{"slt",      32'h0020A1B3, 1'b0, 4, {8'h0, SAW, SER, SD, SF}, 1};
        vecs[4]  = '{"lw",       32'h00402283, 1'b0, 5, {4'h0, SMB, SMR, SMA, SD, SF}, 1};
        vecs[5]  = '{"sw",       32'h0050A223, 1'b0, 4, {8'h0, SMW, SMA, SD, SF}, 0};
        vecs[6]  = '{"ori",      32'h0010E093, 1'b0, 4, {8'h0, SAW, SEI, SD, SF}, 1};
        vecs[7]  = '{"addi_b30", 32'h40000093, 1'b0, 4, {8'h0, SAW, SEI, SD, SF}, 1};
        vecs[8]  = '{"srai",     32'h40105093, 1'b0, 4, {8'h0, SAW, SEI, SD, SF}, 1};
        vecs[9]  = '{"beq_t",    32'h00000063, 1'b1, 3, {12'h0, SBQ, SD, SF}, 0};
        vecs[10] = '{"beq_nt",   32'h00000063, 1'b0, 3, {12'h0, SBQ, SD, SF}, 0};
        vecs[11] = '{"jal",      32'h008000EF, 1'b0, 4, {8'h0, SAW, SJ, SD, SF}, 1};
        vecs[12] = '{"illegal",  32'h00000000, 1'b0, 2, {16'h0, SD, SF}, 0};

        reset = 1'b1;
        instr = 32'h0;
        zero  = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        @(posedge clk);
        #1;
        run_cycle("reset0", SF, 32'h0, 1'b0, 1'b1, 1'b1);
        run_cycle("reset1", SF, 32'h0, 1'b0, 1'b1, 1'b1);
        rw_seen = 0;

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                run_cycle(vecs[i].name, vecs[i].seq[4*k +: 4], vecs[i].ins, vecs[i].z,
                          1'b0, 1'b1);
            end
            check_rw(vecs[i].name, vecs[i].rw);
        end

        // Reset in MEMADR abandons the load; no write enable until the new FETCH.
        run_cycle("rst_mid", SF,  32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("rst_mid", SD,  32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("rst_mid", SMA, 32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("rst_mid", SF,  32'h00402283, 1'b0, 1'b1, 1'b1);
        run_cycle("rst_mid", SF,  32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("rst_mid", SD,  32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("rst_mid", SMA, 32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("rst_mid", SMR, 32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("rst_mid", SMB, 32'h00402283, 1'b0, 1'b0, 1'b1);
        check_rw("rst_mid", 1);

        // Zero toggling inside BEQ must be seen combinationally on PCWrite.
        run_cycle("beq_zc", SF,  32'h00000063, 1'b1, 1'b0, 1'b1);
        run_cycle("beq_zc", SD,  32'h00000063, 1'b1, 1'b0, 1'b1);
        run_cycle("beq_zc", SBQ, 32'h00000063, 1'b1, 1'b0, 1'b1);
        run_cycle("beq_zc", SF,  32'h00000063, 1'b0, 1'b0, 1'b1);
        run_cycle("beq_zc", SD,  32'h00000063, 1'b0, 1'b0, 1'b1);
        run_cycle("beq_zc", SBQ, 32'h00000063, 1'b0, 1'b0, 1'b1);

`ifdef MC_CTRL_MEM_WAIT_EN
        // lw with one FETCH wait and three MEMREAD waits.
        run_cycle("lw_wait", SF,  32'h00402283, 1'b0, 1'b0, 1'b0);
        run_cycle("lw_wait", SF,  32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("lw_wait", SD,  32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("lw_wait", SMA, 32'h00402283, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run_cycle("lw_wait", SMR, 32'h00402283, 1'b0, 1'b0, 1'b0);
        end
        run_cycle("lw_wait", SMR, 32'h00402283, 1'b0, 1'b0, 1'b1);
        run_cycle("lw_wait", SMB, 32'h00402283, 1'b0, 1'b0, 1'b1);
        check_rw("lw_wait", 1);
        // sw with two MEMWRITE waits: MemWrite held throughout.
        run_cycle("sw_wait", SF,  32'h0050A223, 1'b0, 1'b0, 1'b1);
        run_cycle("sw_wait", SD,  32'h0050A223, 1'b0, 1'b0, 1'b1);
        run_cycle("sw_wait", SMA, 32'h0050A223, 1'b0, 1'b0, 1'b1);
        run_cycle("sw_wait", SMW, 32'h0050A223, 1'b0, 1'b0, 1'b0);
        run_cycle("sw_wait", SMW, 32'h0050A223, 1'b0, 1'b0, 1'b0);
        run_cycle("sw_wait", SMW, 32'h0050A223, 1'b0, 1'b0, 1'b1);
        run_cycle("sw_wait", SF,  32'h0050A223, 1'b0, 1'b0, 1'b1);
`endif

        // Trailing FETCH confirms the last instruction returned to FETCH.
        run_cycle("tail", SF, 32'h002081B3, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            fails++;
            $display("FAIL drain: pending %0d expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences a shared-memory, multicycle RV32I datapath: one memory for instructions and data, one ALU reused for PC increment, branch target and execution. Each instruction executes as a series of states, and the block asserts the mux selects and write enables for each state. It is the multicycle counterpart of the single-cycle `controller` and reuses the same 3-bit ALU control encoding and immediate-select encoding.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; forces state to FETCH
- op  in  7  instruction register [6:0]
- funct3  in  3  instruction register [14:12]
- funct7b5  in  1  instruction register [30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete (present only with MC_CTRL_MEM_WAIT_EN)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A (rd1)
- ALUSrcB  out  2  00 B (rd2), 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J (decoded from op)
- RegWrite  out  1  register file write enable
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- State register is 4 bits. Outputs are Moore decodes of state, except:
  - PCWrite = PCUpdate | (Branch & Zero)
  - ALUControl is decoded from ALUOp and funct fields
  - ImmSrc is decoded from op
- ALUOp decode:
  - 00 → add
  - 01 → sub
  - 10 → funct decode: funct3 000 → sub if op[5] & funct7b5, else add; 010 → slt; 110 → or; 111 → and; any other funct3 → add
- States. Unlisted outputs are 0; unlisted selects are 00.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next, by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → FETCH, with illegal_instr=1
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op[5]=0, MEMWRITE otherwise.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- Unused state encodings return to FETCH on the next clock; all outputs are 0 while in them.

## Timing
- State advances on the rising clk edge. All outputs are combinational from the current state and inputs, so they are valid within the same cycle.
- Cycles per instruction, with no wait states:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - beq 3
  - jal 4
  - illegal 2
- Reset:
  - While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and illegal_instr are forced to 0. All other outputs take their FETCH values.
  - The first edge with reset=1 sets state to FETCH.
  - Reset mid-instruction abandons it; no write enable is asserted after the reset edge until FETCH.
- BEQ: PCWrite follows Zero combinationally in the same cycle. If Zero=0, no PC write occurs.

## Configuration
- MC_CTRL_MEM_WAIT_EN defined:
  - The mem_ready port exists.
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - While held in FETCH, IRWrite and PCWrite are 0; both are asserted only in the cycle mem_ready=1.
  - MemWrite stays asserted for the whole MEMWRITE state.
  - Each wait cycle adds one cycle to the instruction.
- MC_CTRL_MEM_WAIT_EN undefined:
  - The mem_ready port does not exist.
  - Memory states last exactly one cycle, as if mem_ready=1.

## Test plan
- reset=1 for 2 cycles, then release → state FETCH; IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10. No write enable is high during reset.
- Apply op/funct fields of add x3,x1,x2 (0x002081B3), then sub (0x402081B3) → state sequence FETCH, DECODE, EXECUTER, ALUWB. ALUControl is 000 for add and 001 for sub. RegWrite=1 only in ALUWB.
- lw 0x00402283, then sw 0x0050A223 → lw passes FETCH, DECODE, MEMADR, MEMREAD, MEMWB (RegWrite, ResultSrc=01). sw passes through MEMWRITE with MemWrite=1 and AdrSrc=1. Total 9 cycles.
- beq 0x00000063 with Zero=1 → PCWrite=1 in BEQ. Repeat with Zero=0 → PCWrite=0. Both take 3 cycles.
- jal 0x008000EF → JAL has PCWrite=1, ALUSrcA=01, ALUSrcB=10, then ALUWB has RegWrite=1. Opcode 0000000 → illegal_instr pulses in DECODE, then FETCH.
- With MC_CTRL_MEM_WAIT_EN, lw with mem_ready low for 3 cycles in MEMREAD → state holds 3 extra cycles; RegWrite is asserted exactly once.
